montgomery_redc_serial: RTL and testbench

- Bit-serial radix-2 Montgomery reduction (REDC): computes R_out = T * 2^-DATA_LENGTH mod N.
- Used to take results out of the Montgomery domain after modular exponentiation. The R mod N and R^2 mod N constants bring operands into the domain; this block performs the reverse conversion and the final reduction.
- Uses a start/done handshake. No N' constant is required.

---
 rtl/montgomery_redc_serial.sv | 121 ++++++++++++
 tb/tb_montgomery_redc_serial.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_redc_serial.sv
// Bit-serial radix-2 Montgomery reduction: R_out = T * 2^-DATA_LENGTH mod N.
// One conditional add-and-halve per clock, then a single final subtraction.
module montgomery_redc_serial #(
  parameter int unsigned DATA_LENGTH = 1024,
  parameter int unsigned CNT_WIDTH   = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2*DATA_LENGTH-1:0]   T_in,
  input  logic [DATA_LENGTH-1:0]     N_in,
  output logic [DATA_LENGTH-1:0]     R_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned AW = 2 * DATA_LENGTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    FIX
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          a_q, a_d;
  logic [DATA_LENGTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] r_out_q, r_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [AW-1:0]          n_ext;
  logic [AW-1:0]          a_sum;
  logic [AW-1:0]          a_fix;

  // Datapath: odd-accumulator correction and final conditional subtraction
  always_comb begin
    n_ext = AW'(n_q);
    a_sum = a_q + n_ext;
    a_fix = (a_q >= n_ext) ? (a_q - n_ext) : a_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    r_out_d = r_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (N_in[0]) begin
            a_d     = {1'b0, T_in};
            n_d     = N_in;
            cnt_d   = CNT_WIDTH'(DATA_LENGTH);
            busy_d  = 1'b1;
            state_d = REDUCE;
          end else begin
            // Even modulus has no inverse of 2: report immediately
            r_out_d = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      REDUCE: begin
        a_d   = a_q[0] ? (a_sum >> 1) : (a_q >> 1);
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        r_out_d = a_fix[DATA_LENGTH-1:0];
        err_d   = (a_fix >= n_ext);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      r_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      r_out_q <= r_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign R_out = r_out_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_montgomery_redc_serial.sv
// Self-checking bench for montgomery_redc_serial with K=8: vector table,
// random vectors against a search-based REDC model, and handshake/reset sequences.
module tb_montgomery_redc_serial;

  localparam int unsigned K   = 8;
  localparam int unsigned CW  = 4;
  localparam int          BOUND = 50;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2*K-1:0] T_in;
  logic [K-1:0]  N_in;
  logic [K-1:0]  R_out;
  logic          busy;
  logic          done;
  logic          err;

  montgomery_redc_serial #(.DATA_LENGTH(K), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .T_in  (T_in),
    .N_in  (N_in),
    .R_out (R_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*K-1:0] t;
    logic [K-1:0]   n;
    logic [K-1:0]   r;
    logic           e;
    int             wait_n;
    int             busy_n;
  } vec_t;

  typedef struct {
    logic [K-1:0] r;
    logic         e;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   ops_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [K-1:0] r, input logic e);
    exp_t x;
    x.r = r;
    x.e = e;
    exp_q.push_back(x);
    ops_total++;
  endtask

  // REDC by exhaustive search for the m that clears the low K bits
  function automatic void model(input int t, input int n, output logic [K-1:0] r, output logic e);
    int m;
    int a;
    m = 0;
    for (int k = 0; k < 256; k++) begin
      if (((t + k * n) % 256) == 0) begin
        m = k;
        break;
      end
    end
    a = (t + m * n) / 256;
    if (a >= n) a = a - n;
    e = (a >= n);
    r = K'(a);
  endfunction

  // Scoreboard: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 expected no done");
      end else begin
        cur = exp_q.pop_front();
        check("r_out", 32'(R_out), 32'(cur.r));
        check("err", 32'(err), 32'(cur.e));
        check("busy_with_done", 32'(busy), 32'd0);
      end
    end
  end

  // Walk negedges until done; optionally drop start and change operands mid-run
  task automatic wait_done(input bit drop_start, input int mod_at,
                           input logic [2*K-1:0] mod_t, input logic [K-1:0] mod_n,
                           output int waited, output int bcnt, output bit seen);
    waited = 0;
    bcnt   = 0;
    seen   = 1'b0;
    while (!seen && waited < BOUND) begin
      @(negedge clk);
      if (drop_start) start = 1'b0;
      waited++;
      if (waited == mod_at) begin
        T_in = mod_t;
        N_in = mod_n;
      end
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", BOUND);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [2*K-1:0] t, input logic [K-1:0] n,
                        input logic [K-1:0] r, input logic e,
                        input int exp_wait, input int exp_busy,
                        input int mod_at, input logic [2*K-1:0] mod_t, input logic [K-1:0] mod_n);
    int waited;
    int bcnt;
    bit seen;
    @(negedge clk);
    T_in  = t;
    N_in  = n;
    start = 1'b1;
    push_exp(r, e);
    wait_done(1'b1, mod_at, mod_t, mod_n, waited, bcnt, seen);
    if (seen) begin
      check("done_latency", 32'(waited), 32'(exp_wait));
      check("busy_cycles", 32'(bcnt), 32'(exp_busy));
    end
  endtask

  vec_t vecs[8];

  initial begin
    int waited;
    int bcnt;
    bit seen;
    logic [K-1:0] mr;
    logic me;
    int rn;
    int rt;

    // Normal ops: done seen on 10th negedge after start raised, busy for 9
    vecs[0] = '{t: 16'd9,     n: 8'd13, r: 8'd1,   e: 1'b0, wait_n: 10, busy_n: 9};
    vecs[1] = '{t: 16'd1,     n: 8'd13, r: 8'd3,   e: 1'b0, wait_n: 10, busy_n: 9};
    vecs[2] = '{t: 16'd3,     n: 8'd13, r: 8'd9,   e: 1'b0, wait_n: 10, busy_n: 9};
    vecs[3] = '{t: 16'd0,     n: 8'd13, r: 8'd0,   e: 1'b0, wait_n: 10, busy_n: 9};
    vecs[4] = '{t: 16'd3327,  n: 8'd13, r: 8'd10,  e: 1'b0, wait_n: 10, busy_n: 9};
    vecs[5] = '{t: 16'd65535, n: 8'd13, r: 8'd253, e: 1'b1, wait_n: 10, busy_n: 9};
    vecs[6] = '{t: 16'd9,     n: 8'd12, r: 8'd0,   e: 1'b1, wait_n: 1,  busy_n: 0};
    vecs[7] = '{t: 16'd1,     n: 8'd1,  r: 8'd0,   e: 1'b0, wait_n: 10, busy_n: 9};

    rst_n = 1'b0;
    start = 1'b0;
    T_in  = '0;
    N_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_r_out", 32'(R_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].t, vecs[i].n, vecs[i].r, vecs[i].e, vecs[i].wait_n, vecs[i].busy_n,
             0, '0, '0);
    end

    for (int i = 0; i < 6; i++) begin
      rn = 2 * int'($urandom_range(1, 127)) + 1;
      rt = int'($urandom_range(0, 32'(rn * 256 - 1)));
      model(rt, rn, mr, me);
      run_op(16'(rt), 8'(rn), mr, me, 10, 9, 0, '0, '0);
    end

    // Operands changed mid-run must not affect the captured ones
    run_op(16'd9, 8'd13, 8'd1, 1'b0, 10, 9, 3, 16'd3327, 8'd11);

    // start held across two operations: second accept follows the done cycle
    @(negedge clk);
    T_in  = 16'd9;
    N_in  = 8'd13;
    start = 1'b1;
    push_exp(8'd1, 1'b0);
    push_exp(8'd9, 1'b0);
    wait_done(1'b0, 1, 16'd3, 8'd13, waited, bcnt, seen);
    if (seen) begin
      check("b2b_first_latency", 32'(waited), 32'd10);
      @(negedge clk);
      check("b2b_reaccept_busy", 32'(busy), 32'd1);
      start = 1'b0;
      wait_done(1'b1, 0, '0, '0, waited, bcnt, seen);
      if (seen) check("b2b_second_latency", 32'(waited), 32'd9);
    end

    // Leave non-zero outputs, then abort an operation with reset
    run_op(16'd65535, 8'd13, 8'd253, 1'b1, 10, 9, 0, '0, '0);
    @(negedge clk);
    T_in  = 16'd9;
    N_in  = 8'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_r_out", 32'(R_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(16'd9, 8'd13, 8'd1, 1'b0, 10, 9, 0, '0, '0);

    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(ops_total));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "global timeout");
  end

endmodule
